// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
// Round-robin arbiter that shares one 4:1 data multiplexer between four
// packet requesters. A grant is held from the first beat until the owner's
// last beat transfers. Beats leave through one registered output stage.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : per-requester beat valid (bit i = requester i)
//   in_last    : per-requester last-beat flag, qualified by in_valid
//   in_data0-3 : per-requester beat data
//   in_ready   : per-requester ready, one-hot or zero
//   out_valid  : registered output beat valid
//   out_data   : registered output beat data
//   out_last   : registered last flag of the output beat
//   out_src    : registered index of the requester that produced the beat
//   out_ready  : downstream accepts the output beat
//   grant_sel  : current owner index, drives the shared mux select
//   busy       : high while a requester holds the grant
module rr_mux_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    input  logic [3:0]   in_last,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic [1:0]   out_src,
    input  logic         out_ready,
    output logic [1:0]   grant_sel,
    output logic         busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_owner;
    logic [1:0]     w_owner_nxt;
    logic [1:0]     r_rr_ptr;
    logic [1:0]     w_rr_ptr_nxt;

    logic           r_out_valid;
    logic [W-1:0]   r_out_data;
    logic           r_out_last;
    logic [1:0]     r_out_src;

    logic           w_can_load;
    logic           w_xfer;
    logic           w_own_valid;
    logic           w_own_last;
    logic [W-1:0]   w_own_data;
    logic [1:0]     w_pick;

    // First requesting index in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    // Scanning from the far end lets the nearest candidate overwrite.
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    // Shared mux: everything about the owner is selected by r_owner.
    always_comb begin
        w_own_data = in_data0;
        case (r_owner)
            2'd0: w_own_data = in_data0;
            2'd1: w_own_data = in_data1;
            2'd2: w_own_data = in_data2;
            2'd3: w_own_data = in_data3;
            default: w_own_data = in_data0;
        endcase
    end

    assign w_own_valid = in_valid[r_owner];
    assign w_own_last  = in_last[r_owner];
    assign w_pick      = rr_pick(in_valid, r_rr_ptr);

    // The output register can take a beat when empty or draining this cycle.
    // in_ready deliberately ignores in_valid to avoid a valid->ready path.
    assign w_can_load = !r_out_valid || out_ready;
    assign w_xfer     = (r_state == S_GRANT) && w_own_valid && w_can_load;

    always_comb begin
        in_ready = 4'b0000;
        if (r_state == S_GRANT && w_can_load) begin
            in_ready[r_owner] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (|in_valid) begin
                    w_owner_nxt = w_pick;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                // Grant is held through gaps; only the last beat releases it.
                if (w_xfer && w_own_last) begin
                    w_rr_ptr_nxt = r_owner + 2'd1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_owner  <= 2'd0;
            r_rr_ptr <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Output stage: a new beat overwrites a draining one with no bubble;
    // payload holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= 2'd0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_own_data;
            r_out_last  <= w_own_last;
            r_out_src   <= r_owner;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;
    assign grant_sel = r_owner;
    assign busy      = (r_state == S_GRANT);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter
// Testbench for rr_mux_arbiter: a table of per-cycle vectors for reset and
// round-robin order, hand-written sequences for multi-cycle corner cases,
// and a randomized run compared against a behavioural reference model.
module tb_rr_mux_arbiter;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [3:0]   in_last;
    logic [W-1:0] dd [4];
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic [1:0]   out_src;
    logic         out_ready;
    logic [1:0]   grant_sel;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    rr_mux_arbiter #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data0  (dd[0]),
        .in_data1  (dd[1]),
        .in_data2  (dd[2]),
        .in_data3  (dd[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .grant_sel (grant_sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; the next rising edge sees reset.
    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        in_last   = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       rst_n;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [3:0] e_d;
        logic       e_l;
        logic [1:0] e_s;
        logic [1:0] e_g;
        logic       e_b;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(logic r, logic o, logic [3:0] rdy, logic ov,
                                logic [3:0] d, logic l, logic [1:0] s,
                                logic [1:0] g, logic b);
        vec_t v;
        v.rst_n = r; v.ordy = o; v.e_rdy = rdy; v.e_ov = ov; v.e_d = d;
        v.e_l = l; v.e_s = s; v.e_g = g; v.e_b = b;
        return v;
    endfunction

    // Reference model state
    bit         m_grant;
    int         m_owner;
    int         m_ptr;
    bit         m_ov;
    logic [3:0] m_od;
    bit         m_ol;
    int         m_os;
    logic [3:0] e_rdy;
    bit         xfer;
    bit         found;
    int         idx;
    logic [3:0] nv, nl;
    logic [3:0] nd [4];

    task automatic m_reset();
        m_grant = 0; m_owner = 0; m_ptr = 0;
        m_ov = 0; m_od = 0; m_ol = 0; m_os = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 4'b0000;
        in_last = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) dd[i] = '0;
        @(negedge clk);

        // ---------------- table: reset with all requesting, then RR 0,1,2,3,0
        tbl[0]  = mk(0, 1, 4'b0000, 0, 4'd0, 0, 2'd0, 2'd0, 0);
        tbl[1]  = mk(0, 1, 4'b0000, 0, 4'd0, 0, 2'd0, 2'd0, 0);
        tbl[2]  = mk(0, 1, 4'b0000, 0, 4'd0, 0, 2'd0, 2'd0, 0);
        tbl[3]  = mk(1, 1, 4'b0000, 0, 4'd0, 0, 2'd0, 2'd0, 0);
        tbl[4]  = mk(1, 1, 4'b0001, 0, 4'd0, 0, 2'd0, 2'd0, 1);
        tbl[5]  = mk(1, 1, 4'b0000, 1, 4'd1, 1, 2'd0, 2'd0, 0);
        tbl[6]  = mk(1, 1, 4'b0010, 0, 4'd0, 0, 2'd0, 2'd1, 1);
        tbl[7]  = mk(1, 1, 4'b0000, 1, 4'd2, 1, 2'd1, 2'd1, 0);
        tbl[8]  = mk(1, 1, 4'b0100, 0, 4'd0, 0, 2'd0, 2'd2, 1);
        tbl[9]  = mk(1, 1, 4'b0000, 1, 4'd3, 1, 2'd2, 2'd2, 0);
        tbl[10] = mk(1, 1, 4'b1000, 0, 4'd0, 0, 2'd0, 2'd3, 1);
        tbl[11] = mk(1, 1, 4'b0000, 1, 4'd4, 1, 2'd3, 2'd3, 0);
        tbl[12] = mk(1, 1, 4'b0001, 0, 4'd0, 0, 2'd0, 2'd0, 1);

        dd[0] = 4'd1; dd[1] = 4'd2; dd[2] = 4'd3; dd[3] = 4'd4;
        for (int i = 0; i < 13; i++) begin
            rst_n = tbl[i].rst_n;
            out_ready = tbl[i].ordy;
            in_valid = 4'b1111;
            in_last = 4'b1111;
            #1;
            chk($sformatf("T%0d_ctrl", i), {in_ready, out_valid, grant_sel, busy},
                {tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_g, tbl[i].e_b});
            if (tbl[i].e_ov)
                chk($sformatf("T%0d_beat", i), {out_data, out_last, out_src},
                    {tbl[i].e_d, tbl[i].e_l, tbl[i].e_s});
            @(negedge clk);
        end

        // ---------------- single requester 2, beats A B C
        do_reset();
        in_valid = 4'b0100; dd[2] = 4'hA;
        #1 chk("A_idle_busy", busy, 0);
        @(negedge clk);
        #1 chk("A_ready", in_ready, 4'b0100);
        chk("A_gsel", grant_sel, 2);
        @(negedge clk);
        dd[2] = 4'hB;
        #1 chk("A_beat0", {out_valid, out_data, out_last, out_src}, {1'b1, 4'hA, 1'b0, 2'd2});
        @(negedge clk);
        dd[2] = 4'hC; in_last = 4'b0100;
        #1 chk("A_beat1", {out_valid, out_data, out_last, out_src}, {1'b1, 4'hB, 1'b0, 2'd2});
        @(negedge clk);
        in_valid = 4'b0000; in_last = 4'b0000;
        #1 chk("A_beat2", {out_valid, out_data, out_last, out_src}, {1'b1, 4'hC, 1'b1, 2'd2});
        chk("A_gap_busy", {busy, in_ready}, 0);
        @(negedge clk);
        #1 chk("A_drained", {out_valid, busy}, 0);

        // ---------------- backpressure on requester 1
        do_reset();
        in_valid = 4'b0010; dd[1] = 4'd5; in_last = 4'b0000;
        @(negedge clk);
        #1 chk("B_ready", in_ready, 4'b0010);
        @(negedge clk);
        dd[1] = 4'd6; in_last = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            out_ready = 1'b0;
            #1 chk($sformatf("B_stall%0d", k), {out_valid, out_data, in_ready}, {1'b1, 4'd5, 4'b0000});
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("B_release", {out_data, in_ready}, {4'd5, 4'b0010});
        @(negedge clk);
        in_valid = 4'b0000; in_last = 4'b0000;
        #1 chk("B_beat1", {out_valid, out_data, out_last, out_src}, {1'b1, 4'd6, 1'b1, 2'd1});
        chk("B_busy", busy, 0);
        @(negedge clk);
        #1 chk("B_drained", out_valid, 0);

        // ---------------- gap mid-packet from requester 3 while 0 waits
        do_reset();
        in_valid = 4'b1000; dd[3] = 4'd7; in_last = 4'b0000;
        @(negedge clk);
        #1 chk("C_grant3", {grant_sel, in_ready}, {2'd3, 4'b1000});
        @(negedge clk);
        in_valid = 4'b0001; dd[0] = 4'd9; in_last = 4'b0001;
        #1 chk("C_gap0", {grant_sel, busy}, {2'd3, 1'b1});
        @(negedge clk);
        #1 chk("C_gap1", {grant_sel, busy, in_ready}, {2'd3, 1'b1, 4'b1000});
        @(negedge clk);
        in_valid = 4'b1001; dd[3] = 4'd8; in_last = 4'b1001;
        #1 chk("C_resume", {grant_sel, in_ready}, {2'd3, 4'b1000});
        @(negedge clk);
        in_valid = 4'b0001; in_last = 4'b0001;
        #1 chk("C_last", {busy, out_valid, out_data, out_last, out_src}, {1'b0, 1'b1, 4'd8, 1'b1, 2'd3});
        @(negedge clk);
        #1 chk("C_next0", {grant_sel, busy, in_ready}, {2'd0, 1'b1, 4'b0001});

        // ---------------- reset mid-packet after rr_ptr has moved to 1
        do_reset();
        in_valid = 4'b0001; in_last = 4'b0001; dd[0] = 4'd2;
        @(negedge clk);
        #1 chk("D_grant0", {grant_sel, in_ready}, {2'd0, 4'b0001});
        @(negedge clk);
        in_valid = 4'b0010; in_last = 4'b0000; dd[1] = 4'd3;
        #1 chk("D_idle", busy, 0);
        @(negedge clk);
        #1 chk("D_grant1", grant_sel, 1);
        @(negedge clk);
        #1 chk("D_mid", {out_valid, busy, grant_sel}, {1'b1, 1'b1, 2'd1});
        rst_n = 1'b0;
        @(negedge clk);
        #1 chk("D_reset", {in_ready, out_valid, grant_sel, busy}, 0);
        rst_n = 1'b1; in_valid = 4'b0011; in_last = 4'b0011;
        @(negedge clk);
        #1 chk("D_ptr0", {grant_sel, busy}, {2'd0, 1'b1});

        // ---------------- randomized run against the reference model
        do_reset();
        m_reset();
        for (int i = 0; i < 4; i++) begin
            nv[i] = ($urandom_range(99) < 60);
            nl[i] = ($urandom_range(2) == 0);
            nd[i] = 4'($urandom);
        end
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(63) != 0);
            out_ready = ($urandom_range(3) != 0);
            in_valid = nv;
            in_last = nl;
            for (int i = 0; i < 4; i++) dd[i] = nd[i];
            #1;
            e_rdy = 4'b0000;
            if (m_grant && (!m_ov || out_ready)) e_rdy[m_owner] = 1'b1;
            chk("R_ctrl", {in_ready, out_valid, grant_sel, busy},
                {e_rdy, m_ov, 2'(m_owner), m_grant});
            if (m_ov)
                chk("R_beat", {out_data, out_last, out_src}, {m_od, m_ol, 2'(m_os)});

            if (!rst_n) begin
                m_reset();
            end else begin
                xfer = m_grant && in_valid[m_owner] && e_rdy[m_owner];
                if (xfer) begin
                    m_ov = 1; m_od = dd[m_owner]; m_ol = in_last[m_owner]; m_os = m_owner;
                end else if (m_ov && out_ready) begin
                    m_ov = 0;
                end
                if (!m_grant) begin
                    found = 0;
                    for (int k = 0; k < 4; k++) begin
                        idx = (m_ptr + k) % 4;
                        if (!found && in_valid[idx]) begin
                            found = 1;
                            m_owner = idx;
                        end
                    end
                    if (found) m_grant = 1;
                end else if (xfer && in_last[m_owner]) begin
                    m_grant = 0;
                    m_ptr = (m_owner + 1) % 4;
                end
            end

            // A pending beat must be held until accepted.
            for (int i = 0; i < 4; i++) begin
                if (!(rst_n && nv[i] && !e_rdy[i])) begin
                    nv[i] = ($urandom_range(99) < 60);
                    nl[i] = ($urandom_range(2) == 0);
                    nd[i] = 4'($urandom);
                end
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one 4:1 data multiplexer between four requesters and drives its select. Each requester offers packets of W-bit beats on a valid/ready/last interface. The arbiter grants one requester at a time and holds the grant until that requester's last beat transfers. Beats pass through a single registered output stage toward one downstream consumer. It sits in front of any shared 4-bit datapath sink that previously took a static mux select.

## Interface
- W, default 4: beat data width.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- in_valid  input  4  per-requester beat valid; bit i belongs to requester i.
- in_last  input  4  per-requester last-beat-of-packet flag; qualified by in_valid[i].
- in_data0, in_data1, in_data2, in_data3  input  W each  per-requester beat data.
- in_ready  output  4  per-requester ready; at most one bit high in any cycle.
- out_valid  output  1  registered output beat valid.
- out_data  output  W  registered output beat data (mux output).
- out_last  output  1  registered copy of the transferred beat's last flag.
- out_src  output  2  registered index of the requester that produced the beat.
- out_ready  input  1  downstream accepts the output beat.
- grant_sel  output  2  current owner index; drives the shared mux select.
- busy  output  1  high while in GRANT state.

## Operation
- States: IDLE, GRANT. Registers: state, owner[1:0], rr_ptr[1:0], output stage (out_valid, out_data, out_last, out_src).
- IDLE behaviour:
  - in_ready = 0.
  - If any in_valid bit is set, pick the first set bit in search order rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
  - Load that index into owner and go to GRANT.
  - If no in_valid bit is set, stay in IDLE.
- GRANT behaviour:
  - in_ready[owner] = (!out_valid || out_ready). All other in_ready bits are 0.
  - Transfer = in_valid[owner] && in_ready[owner]. On transfer, load the output stage with in_data[owner], in_last[owner], out_src = owner, and out_valid = 1.
  - Transfer with in_last[owner] = 1: set rr_ptr = owner+1 (mod 4), go to IDLE.
  - Owner deasserting in_valid mid-packet: grant is held, with no timeout and no preemption.
- Output stage:
  - If out_valid && out_ready and there is no new transfer, out_valid clears.
  - If a transfer and a drain happen in the same cycle, the output stage is overwritten with no bubble.
  - out_data, out_last and out_src hold their values while out_valid && !out_ready.
- grant_sel = owner in all states; its value in IDLE is the previous owner.
- busy = (state == GRANT).
- Requester protocol: in_data, in_last and in_valid must stay stable while in_valid && !in_ready. The arbiter does not check this.

## Timing
- Reset values: state IDLE, owner 0, rr_ptr 0, in_ready 0000, out_valid 0, out_data 0, out_last 0, out_src 0, grant_sel 0, busy 0.
- Reset takes priority over every other event. Reset asserted mid-packet drops the packet: any held output beat is discarded and the arbiter returns to IDLE with rr_ptr 0.
- Arbitration latency: in_valid[i] rising in IDLE at cycle N gives in_ready[i] = 1 in cycle N+1. The first beat transfers at the end of N+1 and out_valid is high in cycle N+2.
- Within a packet: 1 beat/cycle while out_ready stays high.
- Between packets: exactly 1 IDLE cycle, even when other requesters are waiting.
- Single-beat packets: a beat with in_last = 1 on the first transfer returns to IDLE after one GRANT cycle.
- Fairness: with all four requesting continuously, grant order is 0,1,2,3,0,…. No requester waits more than 3 packets.
- in_ready depends combinationally on out_valid and out_ready, but not on in_valid. There is no combinational path from in_valid to in_ready.

## Test plan
- Reset check: hold rst_n = 0 for 3 cycles with all in_valid = 1111 -> in_ready 0000, out_valid 0, grant_sel 0, busy 0. After release, requester 0 is granted first.
- Single requester: requester 2 sends 3 beats A, B, C with last on C, out_ready = 1 -> out_data A, B, C on consecutive cycles, out_src = 2, out_last only on C, then one cycle with busy = 0.
- Round-robin: all four requesters send 1-beat packets continuously -> out_src sequence 0,1,2,3,0,1 with one bubble between packets.
- Backpressure: out_ready = 0 for 4 cycles during a 2-beat packet from requester 1 -> out_data stays at the first beat and in_ready[1] = 0 while stalled. The second beat appears the cycle after out_ready rises, with no beat lost or duplicated.
- Gap and fairness: requester 3 deasserts in_valid for 2 cycles mid-packet while requester 0 requests -> grant stays at 3. After requester 3's last beat, requester 0 is granted next.
- Reset mid-packet: assert rst_n = 0 while requester 1 is mid-packet with out_valid = 1 -> the next cycle shows out_valid 0, state IDLE and rr_ptr 0.
